// File: rtl/pe_acc_drain_pkg.sv
// rtl/pe_acc_drain_pkg.sv - shared datapath widths, bit-width helper and drain FSM states
package GLOBAL_PARAM;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;
  localparam int BATCH  = 4;

  // Address/count width for a structure of n entries; never narrower than one bit.
  function automatic int bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } drain_state_t;

endpackage

// File: rtl/pe_acc_drain_fifo.sv
// rtl/pe_acc_drain_fifo.sv - small synchronous skid FIFO holding requantised output vectors
module drain_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage is cleared on reset so the visible output word is zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pe_acc_drain.sv
// rtl/pe_acc_drain.sv - sweeps the PE accumulation buffer, requantises each vector and streams it out
module pe_acc_drain
  import GLOBAL_PARAM::*;
#(
  parameter int BUF_DEPTH  = 256,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [bw(BUF_DEPTH)-1:0]     base_addr,
  input  logic [bw(BUF_DEPTH):0]       len,
  input  logic [4:0]                   shift,
  output logic                         busy,
  output logic                         done,
  output logic                         buf_release,
  output logic [bw(BUF_DEPTH)-1:0]     abuf_rd_addr,
  input  logic [BATCH*RES_W-1:0]       abuf_rd_data,
  output logic [DATA_W*BATCH-1:0]      out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int AW  = bw(BUF_DEPTH);
  localparam int LW  = AW + 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = bw(FIFO_DEPTH + RD_LAT + 1) + 1;

  localparam logic signed [RES_W-1:0] SAT_HI = {{(RES_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RES_W-1:0] SAT_LO = {{(RES_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  drain_state_t state, state_nx;

  logic [AW-1:0]           addr_q;
  logic [LW-1:0]           len_q;
  logic [4:0]              shift_q;
  logic [LW-1:0]           issued_q;
  logic [LW-1:0]           retired_q;
  logic [LW-1:0]           retired_nx;
  logic [RD_LAT-1:0]       rd_vld;
  logic [CRW-1:0]          inflight;
  logic                    credit_ok;
  logic                    issue;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FCW-1:0]          fifo_count;
  logic [DATA_W*BATCH-1:0] quant_data;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CRW'(rd_vld[i]);
  end

  // Reads still in the RAM pipeline already own a FIFO slot, so the FIFO can never overflow.
  assign credit_ok  = !fifo_full && ((inflight + CRW'(fifo_count)) < CRW'(FIFO_DEPTH));
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = rd_vld[RD_LAT-1];
  assign retired_nx = retired_q + LW'(fifo_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issued_q == len_q) state_nx = S_FLUSH;
      S_FLUSH: if (inflight == '0 && !fifo_push && retired_nx == len_q) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == S_RUN) || (state == S_FLUSH);
    done        = (state == S_DONE);
    buf_release = (state == S_DONE);
    issue       = (state == S_RUN) && (issued_q < len_q) && credit_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else if (state == S_IDLE && start) begin
      addr_q    <= base_addr;
      len_q     <= len;
      shift_q   <= shift;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      if (issue) begin
        issued_q <= issued_q + 1'b1;
        addr_q   <= (addr_q == AW'(BUF_DEPTH - 1)) ? '0 : addr_q + 1'b1;
      end
      retired_q <= retired_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
    end
  end

  assign abuf_rd_addr = addr_q;

  for (genvar g = 0; g < BATCH; g++) begin : g_lane
    logic signed [RES_W-1:0] res;
    logic signed [RES_W-1:0] shifted;
    logic [DATA_W-1:0]       q;

    assign res     = abuf_rd_data[g*RES_W +: RES_W];
    assign shifted = res >>> shift_q;

    always_comb begin
      q = shifted[DATA_W-1:0];
      if (shifted > SAT_HI)      q = {1'b0, {(DATA_W-1){1'b1}}};
      else if (shifted < SAT_LO) q = {1'b1, {(DATA_W-1){1'b0}}};
    end

    assign quant_data[g*DATA_W +: DATA_W] = q;
  end

  drain_fifo #(
    .WIDTH (DATA_W*BATCH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (quant_data),
    .pop       (fifo_pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule
